// File: rtl/trace_pkg.sv
// Shared types and constants for the register-file trace transmitter.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [3:0]  TRACE_MARKER    = 4'hA;
    localparam int unsigned BYTES_PER_FRAME = 3;
    localparam int unsigned ENTRY_W         = 20;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational read data; push is still accepted on a
// full FIFO when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_din,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_trace_tx.sv
// Snoops register-file writes and streams each {addr, data} entry as three
// 8N1 bytes: {marker, addr}, data[15:8], data[7:0].
module rf_trace_tx
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [3:0]                   RF_W_addr,
    input  logic                         RF_W_wr,
    input  logic [15:0]                  W_data,
    input  logic                         Enable,
    output logic                         Tx,
    output logic                         Busy,
    output logic                         Overflow,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_FRAME - 1);

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [BW-1:0]       r_baud;
    logic [2:0]          r_bit_idx;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_shift;
    logic [15:0]         r_data;
    logic                r_overflow;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_bit_end;
    logic [ENTRY_W-1:0]  w_fifo_dout;

    assign w_push    = RF_W_wr & Enable;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign Overflow  = r_overflow;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({RF_W_addr, W_data}),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        Tx          = 1'b1;
        Busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                Tx = 1'b0;
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                Tx = r_shift[0];
                if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_bit_end) w_state_nxt = (r_byte_idx == BYTE_LAST) ? IDLE : START;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

            if (r_state == IDLE || w_bit_end) r_baud <= '0;
            else                              r_baud <= r_baud + 1'b1;

            // The popped entry's address byte goes straight into the shifter;
            // only the data half is kept for the two following bytes.
            if (w_pop) begin
                r_shift    <= {TRACE_MARKER, w_fifo_dout[19:16]};
                r_data     <= w_fifo_dout[15:0];
                r_byte_idx <= '0;
                r_bit_idx  <= '0;
            end

            if (w_bit_end) begin
                case (r_state)
                    START: r_bit_idx <= '0;
                    DATA: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    STOP: begin
                        if (r_byte_idx != BYTE_LAST) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_shift    <= (r_byte_idx == 2'd0) ? r_data[15:8] : r_data[7:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
